sys_bridge_demux: RTL and testbench

- CPU-to-peripheral bridge for the pipelined MIPS core; the demultiplexing counterpart of the datapath select muxes.
- Decodes one CPU bus request and steers it to exactly one of three memory-mapped devices: timer0, timer1 and the output port.
- Waits for that device's ready signal, then returns read data and a completion/error handshake to the CPU.
- Also registers device interrupt lines into the CPU's hardware-interrupt vector.

---
 rtl/sys_bridge_demux.sv | 184 ++++++++++++++++++
 tb/tb_sys_bridge_demux.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/sys_bridge_demux.sv
// sys_bridge_demux: CPU-to-peripheral bridge for the pipelined MIPS core.
// Decodes one CPU bus request, steers it to timer0, timer1 or the output
// port, waits for that device's ready, and returns data plus a one-cycle
// completion/error handshake. Device interrupt levels are registered into
// the CP0 hardware-interrupt vector.
// Optional feature: define BRIDGE_TIMEOUT_EN to bound the WAIT state to
// TIMEOUT_CYCLES cycles, after which the access completes with an error.
module sys_bridge_demux #(
    parameter logic [31:0] DEV0_BASE      = 32'h0000_7F00,
    parameter logic [31:0] DEV1_BASE      = 32'h0000_7F10,
    parameter logic [31:0] DEV2_BASE      = 32'h0000_7F20,
    parameter int          TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        PrReq,
    input  logic        PrWe,
    input  logic [31:0] PrAddr,
    input  logic [31:0] PrWD,
    output logic [31:0] PrRD,
    output logic        PrReady,
    output logic        PrErr,
    output logic [2:0]  DevSel,
    output logic        DevWe,
    output logic [1:0]  DevAddr,
    output logic [31:0] DevWD,
    input  logic [95:0] DevRD,
    input  logic [2:0]  DevReady,
    input  logic [2:0]  DevIRQ,
    output logic [5:0]  HWInt
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t      state_reg, state_next;
    logic [2:0]  sel_reg, sel_next;
    logic        we_reg, we_next;
    logic [1:0]  addr_reg, addr_next;
    logic [31:0] wd_reg, wd_next;
    logic        err_reg, err_next;
    logic [31:0] prrd_reg, prrd_next;
    logic [5:0]  hwint_reg;

`ifdef BRIDGE_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
`endif

    // Byte-lane bits never take part in decode.
    logic unused_addr_bits;
    assign unused_addr_bits = ^PrAddr[1:0];

    logic [2:0]  hit;
    logic [31:0] rd_part [3];
    logic [31:0] rd_slice;
    logic        ready_hit;

    // Per-device word-range decode and read-data slice selection.
    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_dev
            localparam logic [31:0] BASE  = (gi == 0) ? DEV0_BASE :
                                            (gi == 1) ? DEV1_BASE : DEV2_BASE;
            localparam logic [29:0] BASE_W = BASE[31:2];
            localparam logic [29:0] WORDS  = (gi == 2) ? 30'd1 : 30'd3;

            assign hit[gi] = (PrAddr[31:2] >= BASE_W) &&
                             ((PrAddr[31:2] - BASE_W) < WORDS);
            assign rd_part[gi] = sel_reg[gi] ? DevRD[32*gi +: 32] : 32'd0;
        end
    endgenerate

    assign rd_slice  = rd_part[0] | rd_part[1] | rd_part[2];
    // Only the selected device's ready counts; others are ignored.
    assign ready_hit = |(DevReady & sel_reg);

    // State register and latched transaction fields.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= ST_IDLE;
            sel_reg   <= 3'd0;
            we_reg    <= 1'b0;
            addr_reg  <= 2'd0;
            wd_reg    <= 32'd0;
            err_reg   <= 1'b0;
            prrd_reg  <= 32'd0;
`ifdef BRIDGE_TIMEOUT_EN
            cnt_reg   <= '0;
`endif
        end else begin
            state_reg <= state_next;
            sel_reg   <= sel_next;
            we_reg    <= we_next;
            addr_reg  <= addr_next;
            wd_reg    <= wd_next;
            err_reg   <= err_next;
            prrd_reg  <= prrd_next;
`ifdef BRIDGE_TIMEOUT_EN
            cnt_reg   <= cnt_next;
`endif
        end
    end

    // Next-state logic: request capture, device wait, single-cycle response.
    always_comb begin
        state_next = state_reg;
        sel_next   = sel_reg;
        we_next    = we_reg;
        addr_next  = addr_reg;
        wd_next    = wd_reg;
        err_next   = err_reg;
        prrd_next  = prrd_reg;
`ifdef BRIDGE_TIMEOUT_EN
        cnt_next   = cnt_reg;
`endif
        case (state_reg)
            ST_IDLE: begin
                if (PrReq) begin
                    addr_next = PrAddr[3:2];
                    wd_next   = PrWD;
                    we_next   = PrWe;
                    sel_next  = hit;
                    if (|hit) begin
                        state_next = ST_WAIT;
                        err_next   = 1'b0;
`ifdef BRIDGE_TIMEOUT_EN
                        cnt_next   = '0;
`endif
                    end else begin
                        // Unmapped: answer at once with an error and no data.
                        state_next = ST_RESP;
                        err_next   = 1'b1;
                        prrd_next  = 32'd0;
                    end
                end
            end
            ST_WAIT: begin
                if (ready_hit) begin
                    // Ready wins even on the timeout edge.
                    state_next = ST_RESP;
                    err_next   = 1'b0;
                    prrd_next  = we_reg ? 32'd0 : rd_slice;
                end
`ifdef BRIDGE_TIMEOUT_EN
                else if (cnt_reg == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    state_next = ST_RESP;
                    err_next   = 1'b1;
                    prrd_next  = 32'd0;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
`endif
            end
            ST_RESP: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Interrupt levels are registered every edge regardless of bus activity.
    always_ff @(posedge clk) begin
        if (reset) begin
            hwint_reg <= 6'd0;
        end else begin
            hwint_reg <= {3'b000, DevIRQ};
        end
    end

    assign DevSel  = (state_reg == ST_WAIT) ? sel_reg : 3'd0;
    assign DevWe   = (state_reg == ST_WAIT) && we_reg;
    assign DevAddr = addr_reg;
    assign DevWD   = wd_reg;
    assign PrReady = (state_reg == ST_RESP);
    assign PrErr   = (state_reg == ST_RESP) && err_reg;
    assign PrRD    = prrd_reg;
    assign HWInt   = hwint_reg;

endmodule

// File: tb/tb_sys_bridge_demux.sv
// Directed testbench for sys_bridge_demux: reset, mapped reads/writes,
// unmapped errors, interrupt registering and WAIT timeout behaviour.
module tb_sys_bridge_demux;

    logic        clk;
    logic        reset;
    logic        PrReq;
    logic        PrWe;
    logic [31:0] PrAddr;
    logic [31:0] PrWD;
    logic [31:0] PrRD;
    logic        PrReady;
    logic        PrErr;
    logic [2:0]  DevSel;
    logic        DevWe;
    logic [1:0]  DevAddr;
    logic [31:0] DevWD;
    logic [95:0] DevRD;
    logic [2:0]  DevReady;
    logic [2:0]  DevIRQ;
    logic [5:0]  HWInt;

    int checks = 0;
    int errors = 0;

    sys_bridge_demux dut (
        .clk      (clk),
        .reset    (reset),
        .PrReq    (PrReq),
        .PrWe     (PrWe),
        .PrAddr   (PrAddr),
        .PrWD     (PrWD),
        .PrRD     (PrRD),
        .PrReady  (PrReady),
        .PrErr    (PrErr),
        .DevSel   (DevSel),
        .DevWe    (DevWe),
        .DevAddr  (DevAddr),
        .DevWD    (DevWD),
        .DevRD    (DevRD),
        .DevReady (DevReady),
        .DevIRQ   (DevIRQ),
        .HWInt    (HWInt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count one comparison and report it on mismatch.
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end else begin
            $display("ok   %s = %h", tag, got);
        end
    endtask

    // Advance one clock; outputs are sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic seen;
        reset    = 1'b1;
        PrReq    = 1'b0;
        PrWe     = 1'b0;
        PrAddr   = 32'd0;
        PrWD     = 32'd0;
        DevRD    = 96'd0;
        DevReady = 3'd0;
        DevIRQ   = 3'b111;   // reset must win over a live IRQ
        tick();
        tick();
        check("rst_prrd",    PrRD,    32'd0);
        check("rst_prready", {31'd0, PrReady}, 32'd0);
        check("rst_prerr",   {31'd0, PrErr},   32'd0);
        check("rst_devsel",  {29'd0, DevSel},  32'd0);
        check("rst_devwe",   {31'd0, DevWe},   32'd0);
        check("rst_devaddr", {30'd0, DevAddr}, 32'd0);
        check("rst_devwd",   DevWD,   32'd0);
        check("rst_hwint",   {26'd0, HWInt},   32'd0);
        reset  = 1'b0;
        DevIRQ = 3'd0;
        tick();

        // Reset in the middle of a pending read to 0x7F04.
        PrReq = 1'b1; PrWe = 1'b0; PrAddr = 32'h0000_7F04;
        tick();
        check("midrst_wait_sel",  {29'd0, DevSel},  32'd1);
        check("midrst_wait_addr", {30'd0, DevAddr}, 32'd1);
        PrReq = 1'b0;
        reset = 1'b1;
        tick();
        check("midrst_sel",     {29'd0, DevSel},  32'd0);
        check("midrst_prready", {31'd0, PrReady}, 32'd0);
        check("midrst_devaddr", {30'd0, DevAddr}, 32'd0);
        reset = 1'b0;
        DevReady = 3'b111;
        tick();
        check("midrst_noresp", {31'd0, PrReady}, 32'd0);
        DevReady = 3'd0;
        tick();

        // Write 0x7F14, timer1 ready on the first WAIT cycle.
        PrReq = 1'b1; PrWe = 1'b1; PrAddr = 32'h0000_7F14; PrWD = 32'hA5A5_0001;
        tick();
        check("wr_sel",     {29'd0, DevSel},  32'b010);
        check("wr_we",      {31'd0, DevWe},   32'd1);
        check("wr_addr",    {30'd0, DevAddr}, 32'd1);
        check("wr_wd",      DevWD,            32'hA5A5_0001);
        check("wr_wait_rdy",{31'd0, PrReady}, 32'd0);
        DevReady = 3'b010;
        tick();
        check("wr_prready", {31'd0, PrReady}, 32'd1);
        check("wr_prerr",   {31'd0, PrErr},   32'd0);
        check("wr_prrd",    PrRD,             32'd0);
        check("wr_resp_sel",{29'd0, DevSel},  32'd0);
        PrReq = 1'b0; PrWe = 1'b0; DevReady = 3'd0;
        tick();
        check("wr_idle_rdy",{31'd0, PrReady}, 32'd0);

        // Read 0x7F20, output port ready after 3 WAIT cycles; other slices hold junk.
        DevRD = {32'h0000_00FF, 32'h1111_2222, 32'hDEAD_BEEF};
        PrReq = 1'b1; PrAddr = 32'h0000_7F20;
        DevReady = 3'b001;   // unselected device ready must be ignored
        tick();
        check("rd2_sel_c1", {29'd0, DevSel}, 32'b100);
        check("rd2_we",     {31'd0, DevWe},  32'd0);
        tick();
        check("rd2_sel_c2", {29'd0, DevSel}, 32'b100);
        tick();
        check("rd2_sel_c3", {29'd0, DevSel}, 32'b100);
        check("rd2_c3_rdy", {31'd0, PrReady}, 32'd0);
        DevReady = 3'b101;
        tick();
        check("rd2_prready", {31'd0, PrReady}, 32'd1);
        check("rd2_prrd",    PrRD,             32'h0000_00FF);
        check("rd2_prerr",   {31'd0, PrErr},   32'd0);
        PrReq = 1'b0; DevReady = 3'd0;
        tick();
        check("rd2_pulse", {31'd0, PrReady}, 32'd0);
        check("rd2_hold",  PrRD,             32'h0000_00FF);

        // Read 0x7F08: last word of timer0.
        PrReq = 1'b1; PrAddr = 32'h0000_7F08;
        tick();
        check("rd0_sel",  {29'd0, DevSel},  32'b001);
        check("rd0_addr", {30'd0, DevAddr}, 32'd2);
        DevReady = 3'b001;
        tick();
        check("rd0_prrd", PrRD, 32'hDEAD_BEEF);
        PrReq = 1'b0; DevReady = 3'd0;
        tick();

        // Read 0x7F0C (gap after timer0): immediate error.
        PrReq = 1'b1; PrAddr = 32'h0000_7F0C;
        tick();
        check("um_sel",     {29'd0, DevSel},  32'd0);
        check("um_prready", {31'd0, PrReady}, 32'd1);
        check("um_prerr",   {31'd0, PrErr},   32'd1);
        check("um_prrd",    PrRD,             32'd0);
        PrReq = 1'b0;
        tick();
        check("um_done", {31'd0, PrReady}, 32'd0);

        // Write 0x7F24 (past the 1-word output port): error, no write strobe.
        PrReq = 1'b1; PrWe = 1'b1; PrAddr = 32'h0000_7F24;
        tick();
        check("um2_we",    {31'd0, DevWe}, 32'd0);
        check("um2_prerr", {31'd0, PrErr}, 32'd1);
        PrReq = 1'b0; PrWe = 1'b0;
        tick();

        // IRQ pulse during an in-flight read of timer1.
        PrReq = 1'b1; PrAddr = 32'h0000_7F10; DevIRQ = 3'b101;
        tick();
        check("irq_hwint", {26'd0, HWInt},  32'b000101);
        check("irq_sel",   {29'd0, DevSel}, 32'b010);
        DevIRQ = 3'd0; PrReq = 1'b0;
        tick();
        check("irq_clear", {26'd0, HWInt},  32'd0);
        check("irq_sel2",  {29'd0, DevSel}, 32'b010);
        DevReady = 3'b010;
        tick();
        check("irq_resp", {31'd0, PrReady}, 32'd1);
        DevReady = 3'd0;
        tick();

        // Read 0x7F00 with no device ready ever.
        PrReq = 1'b1; PrAddr = 32'h0000_7F00;
        tick();
        PrReq = 1'b0;
`ifdef BRIDGE_TIMEOUT_EN
        seen = 1'b0;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (PrReady) seen = 1'b1;
        end
        check("to_early", {31'd0, seen}, 32'd0);
        tick();
        check("to_prready", {31'd0, PrReady}, 32'd1);
        check("to_prerr",   {31'd0, PrErr},   32'd1);
        check("to_prrd",    PrRD,             32'd0);
        check("to_sel",     {29'd0, DevSel},  32'd0);
        tick();
`else
        seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (PrReady) seen = 1'b1;
        end
        check("nto_noresp", {31'd0, seen},   32'd0);
        check("nto_sel",    {29'd0, DevSel}, 32'b001);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("nto_rst_sel", {29'd0, DevSel}, 32'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
